tlb_entry_array: RTL and testbench

Fully associative TLB entry store, successor to the flop-array TLB RAM. It holds VPN/ASID tags alongside the cached PTE and performs the match internally. It chooses its own victim on refill: the first invalid entry, otherwise round-robin. It also runs a multi-cycle SFENCE.VMA-style flush walker with all/ASID/VPN/VPN+ASID modes. It sits in the MMU between the TLB control logic and the page table walker refill path.

---
 rtl/tlb_entry_array.sv | 127 ++++++++++++
 tb/tb_tlb_entry_array.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_entry_array.sv
// tlb_entry_array: fully associative TLB store with internal match, self-chosen refill victim and flush walker (TLB_REGISTERED_READ_EN registers lookup outputs)
module tlb_entry_array #(
  parameter int TLB_ENTRIES = 8,
  parameter int VPN_BITS    = 27,
  parameter int PPN_BITS    = 44,
  parameter int ASID_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VPN_BITS-1:0]    LookupVPN,
  input  logic [ASID_BITS-1:0]   LookupASID,
  output logic                   Hit,
  output logic [PPN_BITS-1:0]    HitPPN,
  output logic [7:0]             HitAccessBits,
  input  logic                   WriteEn,
  input  logic [VPN_BITS-1:0]    WriteVPN,
  input  logic [ASID_BITS-1:0]   WriteASID,
  input  logic [PPN_BITS+9:0]    WritePTE,
  output logic                   WriteReady,
  input  logic                   FlushReq,
  input  logic [1:0]             FlushMode,
  input  logic [VPN_BITS-1:0]    FlushVPN,
  input  logic [ASID_BITS-1:0]   FlushASID,
  output logic                   FlushBusy,
  output logic                   FlushDone
);
  localparam int IW = $clog2(TLB_ENTRIES);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t state, state_n;
  logic [TLB_ENTRIES-1:0] valid, lk_match, wr_match;
  logic [VPN_BITS-1:0] vpn [TLB_ENTRIES];
  logic [ASID_BITS-1:0] asid [TLB_ENTRIES];
  logic [PPN_BITS-1:0] ppn [TLB_ENTRIES];
  logic [7:0] acc [TLB_ENTRIES];
  logic [IW-1:0] ptr, idx, wr_idx;
  logic [1:0] f_mode;
  logic [VPN_BITS-1:0] f_vpn;
  logic [ASID_BITS-1:0] f_asid;
  logic wr_fire, wr_hit, wr_free, fl_clr, fl_vpn_ok, fl_asid_ok, fl_g, hit_c;
  logic [PPN_BITS-1:0] ppn_c;
  logic [7:0] acc_c;
  logic unused_rsw;
  assign unused_rsw = ^WritePTE[9:8];
  for (genvar e = 0; e < TLB_ENTRIES; e++) begin : g_match
    assign lk_match[e] = valid[e] && vpn[e] == LookupVPN && (acc[e][5] || asid[e] == LookupASID);
    assign wr_match[e] = valid[e] && vpn[e] == WriteVPN && (acc[e][5] || asid[e] == WriteASID);
  end
  // OR the single matching row onto the lookup result; blank while the walker runs
  always_comb begin
    ppn_c = '0;
    acc_c = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      ppn_c |= lk_match[i] ? ppn[i] : '0;
      acc_c |= lk_match[i] ? acc[i] : '0;
    end
    hit_c = |lk_match && !FlushBusy;
    ppn_c = FlushBusy ? '0 : ppn_c;
    acc_c = FlushBusy ? '0 : acc_c;
  end
  // refill target: existing tag, else lowest free slot, else round-robin pointer
  always_comb begin
    wr_idx = ptr;
    wr_hit = |wr_match;
    wr_free = !(&valid);
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) wr_idx = valid[i] ? wr_idx : IW'(i);
    for (int i = 0; i < TLB_ENTRIES; i++) wr_idx = wr_match[i] ? IW'(i) : wr_idx;
  end
  assign wr_fire = WriteEn && WriteReady;
  assign fl_g = acc[idx][5];
  assign fl_vpn_ok = vpn[idx] == f_vpn;
  assign fl_asid_ok = asid[idx] == f_asid && !fl_g;
  assign fl_clr = f_mode == 2'b00 ? 1'b1 : f_mode == 2'b01 ? fl_asid_ok :
                  f_mode == 2'b10 ? fl_vpn_ok : fl_vpn_ok && fl_asid_ok;
  // valid bits and round-robin pointer; the walker clears one entry per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      ptr <= '0;
    end else begin
      if (wr_fire) valid[wr_idx] <= 1'b1;
      if (wr_fire && !wr_hit && !wr_free) ptr <= ptr + 1'b1;
      if (state == WALK && fl_clr) valid[idx] <= 1'b0;
    end
  end
  // entry payload captured on refill
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      vpn[wr_idx] <= WriteVPN;
      asid[wr_idx] <= WriteASID;
      ppn[wr_idx] <= WritePTE[PPN_BITS+9:10];
      acc[wr_idx] <= WritePTE[7:0];
    end
  end
  // flush state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // flush next state
  always_comb state_n = state == IDLE ? (FlushReq ? WALK : IDLE) :
                        state == WALK ? (idx == IW'(TLB_ENTRIES - 1) ? DONE : WALK) : IDLE;
  // flush status outputs
  always_comb begin
    FlushBusy = state != IDLE;
    FlushDone = state == DONE;
    WriteReady = state == IDLE;
  end
  // flush operand capture and walk index
  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else if (state == IDLE && FlushReq) begin
      f_mode <= FlushMode;
      f_vpn <= FlushVPN;
      f_asid <= FlushASID;
      idx <= '0;
    end else if (state == WALK) idx <= idx + 1'b1;
  end
`ifdef TLB_REGISTERED_READ_EN
  // registered lookup result, held at zero on reset and for every busy cycle
  always_ff @(posedge clk) begin
    Hit <= !reset && state_n == IDLE && hit_c;
    HitPPN <= (reset || state_n != IDLE) ? '0 : ppn_c;
    HitAccessBits <= (reset || state_n != IDLE) ? '0 : acc_c;
  end
`else
  assign Hit = hit_c;
  assign HitPPN = ppn_c;
  assign HitAccessBits = acc_c;
`endif
endmodule

// File: tb/tb_tlb_entry_array.sv
// tb_tlb_entry_array: scoreboard bench against a behavioural TLB model
module tb_tlb_entry_array;
  localparam int N = 8, VB = 27, PB = 44, AB = 16, PW = PB + 10;
  logic clk = 0, reset;
  logic [VB-1:0] LookupVPN, WriteVPN, FlushVPN;
  logic [AB-1:0] LookupASID, WriteASID, FlushASID;
  logic Hit, WriteEn, WriteReady, FlushReq, FlushBusy, FlushDone;
  logic [PB-1:0] HitPPN;
  logic [7:0] HitAccessBits;
  logic [PW-1:0] WritePTE;
  logic [1:0] FlushMode;
  tlb_entry_array dut (
    .clk(clk), .reset(reset), .LookupVPN(LookupVPN), .LookupASID(LookupASID),
    .Hit(Hit), .HitPPN(HitPPN), .HitAccessBits(HitAccessBits),
    .WriteEn(WriteEn), .WriteVPN(WriteVPN), .WriteASID(WriteASID), .WritePTE(WritePTE),
    .WriteReady(WriteReady), .FlushReq(FlushReq), .FlushMode(FlushMode),
    .FlushVPN(FlushVPN), .FlushASID(FlushASID), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; logic hit; logic [PB-1:0] ppn; logic [7:0] acc;} lk_t;
  typedef struct {int due; logic busy; logic done;} st_t;
  lk_t lq[$];
  st_t sq[$];
  int n_tests = 0, n_fail = 0;
  logic m_valid [N];
  logic [VB-1:0] m_vpn [N];
  logic [AB-1:0] m_asid [N];
  logic [PW-1:0] m_pte [N];
  int m_ptr, m_busy_left;
  function automatic int m_find(input logic [VB-1:0] v, input logic [AB-1:0] a);
    int r = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_vpn[i] == v && (m_pte[i][5] || m_asid[i] == a)) r = i;
    return r;
  endfunction
  function automatic logic [PW-1:0] mkpte(input logic [PB-1:0] p, input logic [7:0] a);
    return {p, 2'b00, a};
  endfunction
  task automatic step();
    int k, w;
    logic busy, clr;
    lk_t l;
    st_t s;
    busy = m_busy_left > 0;
    s.due = cyc; s.busy = busy; s.done = m_busy_left == 1;
    sq.push_back(s);
    k = m_find(LookupVPN, LookupASID);
    l.hit = !busy && k >= 0; l.ppn = '0; l.acc = '0;
    if (WriteEn && !busy) begin
      w = m_find(WriteVPN, WriteASID);
      if (w < 0) for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) w = i;
      if (w < 0) begin w = m_ptr; m_ptr = (m_ptr + 1) % N; end
      m_valid[w] = 1; m_vpn[w] = WriteVPN; m_asid[w] = WriteASID;
      if (l.hit && k == w) l.ppn = m_pte[k][PW-1:10];
      if (l.hit && k == w) l.acc = m_pte[k][7:0];
      m_pte[w] = WritePTE;
    end
    if (l.hit && !(WriteEn && !busy && k == w)) begin
      l.ppn = m_pte[k][PW-1:10];
      l.acc = m_pte[k][7:0];
    end
    if (FlushReq && !busy) begin
      for (int i = 0; i < N; i++) begin
        case (FlushMode)
          2'b00: clr = 1;
          2'b01: clr = m_asid[i] == FlushASID && !m_pte[i][5];
          2'b10: clr = m_vpn[i] == FlushVPN;
          default: clr = m_vpn[i] == FlushVPN && m_asid[i] == FlushASID && !m_pte[i][5];
        endcase
        if (clr) m_valid[i] = 0;
      end
      m_busy_left = N + 1;
    end else if (busy) m_busy_left--;
`ifdef TLB_REGISTERED_READ_EN
    l.due = cyc + 1;
    if (m_busy_left > 0) begin l.hit = 0; l.ppn = '0; l.acc = '0; end
`else
    l.due = cyc;
`endif
    lq.push_back(l);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    lk_t l;
    reset = 1; WriteEn = 0; FlushReq = 0;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_ptr = 0; m_busy_left = 0;
`ifdef TLB_REGISTERED_READ_EN
    l.due = cyc; l.hit = 0; l.ppn = '0; l.acc = '0;
    lq.push_back(l);
`endif
  endtask
  task automatic wr(input int v, input int a, input logic [PW-1:0] p);
    WriteEn = 1; WriteVPN = VB'(v); WriteASID = AB'(a); WritePTE = p;
    step();
    WriteEn = 0;
  endtask
  task automatic lk(input int v, input int a);
    LookupVPN = VB'(v); LookupASID = AB'(a);
    step();
  endtask
  task automatic fl(input int m, input int v, input int a);
    FlushReq = 1; FlushMode = 2'(m); FlushVPN = VB'(v); FlushASID = AB'(a);
    step();
    FlushReq = 0;
  endtask
  // monitor: compare every expectation that has come due
  always @(negedge clk) begin
    lk_t l;
    st_t s;
    while (lq.size() > 0 && lq[0].due <= cyc) begin
      l = lq.pop_front();
      n_tests++;
      if (Hit !== l.hit || HitPPN !== l.ppn || HitAccessBits !== l.acc) begin
        n_fail++;
        $display("FAIL lookup cyc %0d: got hit=%0b ppn=%h acc=%h, want hit=%0b ppn=%h acc=%h",
                 cyc, Hit, HitPPN, HitAccessBits, l.hit, l.ppn, l.acc);
      end
    end
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      n_tests++;
      if (FlushBusy !== s.busy || FlushDone !== s.done || WriteReady !== !s.busy) begin
        n_fail++;
        $display("FAIL status cyc %0d: got busy=%0b done=%0b ready=%0b, want busy=%0b done=%0b ready=%0b",
                 cyc, FlushBusy, FlushDone, WriteReady, s.busy, s.done, !s.busy);
      end
    end
  end
  initial begin
    WriteEn = 0; FlushReq = 0; FlushMode = 0; FlushVPN = 0; FlushASID = 0;
    WriteVPN = 0; WriteASID = 0; WritePTE = 0; LookupVPN = 0; LookupASID = 0;
    do_reset();
    lk(32'h123, 1);
    for (int i = 0; i < 8; i++) begin
      LookupVPN = VB'(i);
      wr(i, 1, mkpte(PB'(32'h100 + i), 8'h0F + 8'(i)));
    end
    for (int i = 0; i < 8; i++) lk(i, 1);
    wr(8, 1, mkpte(44'h108, 8'hC7));
    lk(0, 1); lk(8, 1);
    wr(9, 1, mkpte(44'h109, 8'hC7));
    lk(1, 1); lk(2, 1);
    wr(3, 1, mkpte(44'hABC, 8'h4F));
    lk(3, 1);
    wr(10, 1, mkpte(44'h10A, 8'h0F));
    lk(2, 1); lk(3, 1); lk(10, 1);
    fl(0, 0, 0);
    repeat (N + 1) step();
    lk(3, 1);
    wr(5, 2, mkpte(44'h555, 8'h21));
    wr(6, 2, mkpte(44'h666, 8'h01));
    wr(7, 3, mkpte(44'h777, 8'h03));
    lk(5, 7); lk(6, 7); lk(6, 2);
    fl(1, 0, 2);
    repeat (N + 1) step();
    lk(5, 7); lk(6, 2); lk(7, 3);
    fl(0, 0, 0);
    WriteEn = 1; WriteVPN = 20; WriteASID = 1; WritePTE = mkpte(44'h2020, 8'h0B);
    LookupVPN = 20; LookupASID = 1;
    step(); step();
    FlushReq = 1; FlushMode = 0;
    step();
    FlushReq = 0;
    repeat (N) step();
    WriteEn = 0;
    lk(20, 1); lk(20, 1);
    WriteEn = 1; WriteVPN = 30; WriteASID = 1; WritePTE = mkpte(44'h3030, 8'h0F);
    FlushReq = 1; FlushMode = 2'b10; FlushVPN = 30;
    step();
    WriteEn = 0; FlushReq = 0;
    repeat (N + 1) step();
    lk(30, 1); lk(20, 1);
    wr(40, 1, mkpte(44'h4040, 8'h0F));
    fl(0, 0, 0);
    repeat (3) step();
    do_reset();
    lk(40, 1); lk(20, 1);
    for (int t = 0; t < 600; t++) begin
      WriteEn = $urandom_range(99) < 40;
      WriteVPN = VB'($urandom_range(15)); WriteASID = AB'($urandom_range(3));
      WritePTE = mkpte(PB'({$urandom(), $urandom()}), 8'($urandom()) & 8'hDF);
      FlushReq = $urandom_range(99) < 3;
      FlushMode = 2'($urandom_range(3));
      FlushVPN = VB'($urandom_range(15)); FlushASID = AB'($urandom_range(3));
      LookupVPN = VB'($urandom_range(15)); LookupASID = AB'($urandom_range(3));
      step();
    end
    WriteEn = 0; FlushReq = 0;
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
